// File: rtl/stepper_phase_decoder_pkg.sv
// Shared constants and types for the stepper phase decoder.
// Direction codes are common with the drive and the controller.
package stepper_phase_decoder_pkg;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_STOP = 2'b11;

  localparam logic [3:0] PH0 = 4'h3;
  localparam logic [3:0] PH1 = 4'h9;
  localparam logic [3:0] PH2 = 4'hC;
  localparam logic [3:0] PH3 = 4'h6;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

endpackage

// File: rtl/phase_index_decode.sv
// Coil pattern to phase index lookup.
// Anything outside the four full-step patterns is flagged invalid.
module phase_index_decode
  import stepper_phase_decoder_pkg::*;
(
  input  logic [3:0] phase,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    unique case (1'b1)
      (phase == PH0): begin
        idx   = 2'd0;
        valid = 1'b1;
      end
      (phase == PH1): begin
        idx   = 2'd1;
        valid = 1'b1;
      end
      (phase == PH2): begin
        idx   = 2'd2;
        valid = 1'b1;
      end
      (phase == PH3): begin
        idx   = 2'd3;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Recovers steps, direction and floor position from the coil pattern.
// All outputs are registered and reflect the phase sampled at the last edge.
module stepper_phase_decoder
  import stepper_phase_decoder_pkg::*;
#(
  parameter int NUM_FLOORS      = 4,
  parameter int STEPS_PER_FLOOR = 8,
  parameter int FLOOR_W         = 2,
  parameter int SUB_W           = 3,
  parameter int IDLE_CYCLES     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         phase,
  input  logic               home,
  output logic [FLOOR_W-1:0] floor,
  output logic [SUB_W-1:0]   sub_step,
  output logic               at_floor,
  output logic [1:0]         dir,
  output logic               step_pulse,
  output logic               phase_err,
  output logic               limit_err
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [FLOOR_W-1:0] TOP_FL = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(STEPS_PER_FLOOR - 1);

  state_t             state_q, state_n;
  logic [1:0]         idx_q, idx_n;
  logic [FLOOR_W-1:0] floor_q, floor_n;
  logic [SUB_W-1:0]   sub_q, sub_n;
  logic [IW-1:0]      idle_q, idle_n;
  logic [1:0]         dir_q, dir_n;
  logic               atf_q, atf_n;
  logic               sp_q, sp_n;
  logic               pe_q, pe_n;
  logic               le_q, le_n;

  logic [1:0] ph_idx;
  logic       ph_valid;
  logic [1:0] delta;
  logic       up, dn;
  logic       at_lo, at_hi;

  phase_index_decode u_dec (
    .phase (phase),
    .idx   (ph_idx),
    .valid (ph_valid)
  );

  assign delta = ph_idx - idx_q;
  assign at_lo = (floor_q == '0) && (sub_q == '0);
  assign at_hi = (floor_q == TOP_FL) && (sub_q == '0);

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    floor_n = floor_q;
    sub_n   = sub_q;
    idle_n  = idle_q;
    dir_n   = dir_q;
    sp_n    = 1'b0;
    pe_n    = 1'b0;
    le_n    = 1'b0;
    up      = 1'b0;
    dn      = 1'b0;

    unique case (state_q)
      UNLOCKED: begin
        idle_n = '0;
        dir_n  = DIR_NONE;
        if (ph_valid) begin
          state_n = LOCKED;
          idx_n   = ph_idx;
          dir_n   = DIR_STOP;
        end
      end
      LOCKED: begin
        if (!ph_valid) begin
          state_n = UNLOCKED;
          pe_n    = 1'b1;
          dir_n   = DIR_NONE;
          idle_n  = '0;
        end else begin
          idx_n = ph_idx;
          unique case (delta)
            2'd1: up = 1'b1;
            2'd3: dn = 1'b1;
            2'd2: begin
              pe_n = 1'b1;
              if (idle_q != IDLE_MAX) idle_n = idle_q + IW'(1);
            end
            2'd0: begin
              if (idle_q != IDLE_MAX) idle_n = idle_q + IW'(1);
            end
          endcase
        end
      end
    endcase

    // Attempted steps set direction even when the limit rejects them
    if (up || dn) begin
      idle_n = '0;
      dir_n  = up ? DIR_UP : DIR_DOWN;
    end

    if (home) begin
      floor_n = '0;
      sub_n   = '0;
      idle_n  = '0;
    end else if (up) begin
      if (at_hi) begin
        le_n = 1'b1;
      end else begin
        sp_n = 1'b1;
        if (sub_q == LAST_SUB) begin
          sub_n   = '0;
          floor_n = floor_q + FLOOR_W'(1);
        end else begin
          sub_n = sub_q + SUB_W'(1);
        end
      end
    end else if (dn) begin
      if (at_lo) begin
        le_n = 1'b1;
      end else begin
        sp_n = 1'b1;
        if (sub_q == '0) begin
          sub_n   = LAST_SUB;
          floor_n = floor_q - FLOOR_W'(1);
        end else begin
          sub_n = sub_q - SUB_W'(1);
        end
      end
    end

    if ((state_n == LOCKED) && (idle_n == IDLE_MAX)) dir_n = DIR_STOP;

    atf_n = (state_n == LOCKED) && (sub_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      idx_q   <= '0;
      floor_q <= '0;
      sub_q   <= '0;
      idle_q  <= '0;
      dir_q   <= DIR_NONE;
      atf_q   <= 1'b0;
      sp_q    <= 1'b0;
      pe_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      floor_q <= floor_n;
      sub_q   <= sub_n;
      idle_q  <= idle_n;
      dir_q   <= dir_n;
      atf_q   <= atf_n;
      sp_q    <= sp_n;
      pe_q    <= pe_n;
      le_q    <= le_n;
    end
  end

  assign floor      = floor_q;
  assign sub_step   = sub_q;
  assign at_floor   = atf_q;
  assign dir        = dir_q;
  assign step_pulse = sp_q;
  assign phase_err  = pe_q;
  assign limit_err  = le_q;

endmodule
